// File: rtl/dcm_reset_sequencer.sv
// dcm_reset_sequencer
//
// Brings up the board clock DCM and produces the reset for all divided-clock logic
// (including the four-digit LED driver). The block pulses the DCM RST pin, waits
// for LOCKED, and releases the system reset only after the lock has stayed up for a
// qualified interval. If the lock is lost or the input clock stops, the DCM is reset
// again. After a bounded number of retries the block parks in a terminal FAIL state.
// It must be clocked from the buffered DCM input clock, never from a DCM output.
//
// Optional feature: define DCM_LOCK_SYNC_EN to pass dcm_locked_i through a 2-flop
// synchronizer. This delays every lock-driven transition by two cycles.
//
// Ports:
//   clk_i               buffered DCM input clock
//   reset_i             asynchronous active-high reset for the whole block
//   dcm_locked_i        DCM LOCKED output
//   dcm_clkin_stopped_i DCM STATUS[1], input clock stopped
//   dcm_rst_o           DCM RST pin (registered)
//   sys_rst_o           active-high reset for the divided-clock logic (registered)
//   lock_ok_o           high only in RUN
//   fail_o              sticky, set when retries are exhausted
//   retry_cnt_o         retries performed; saturates; cleared only by reset
//   state_o             FSM state: 0 ASSERT_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL
module dcm_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       dcm_locked_i,
  input  logic       dcm_clkin_stopped_i,
  output logic       dcm_rst_o,
  output logic       sys_rst_o,
  output logic       lock_ok_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StAssertRst = 3'd0,
    StWaitLock  = 3'd1,
    StStable    = 3'd2,
    StRun       = 3'd3,
    StFail      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RstLast    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLast   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [3:0]       MaxRetry   = 4'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             dcm_rst_q, dcm_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             lock_ok_q, lock_ok_d;
  logic             fail_q, fail_d;
  logic             lk;
  logic             lk_good;
  logic             take_retry;

`ifdef DCM_LOCK_SYNC_EN
  logic [1:0] lk_sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lk_sync_q <= 2'b00;
    end else begin
      lk_sync_q <= {lk_sync_q[0], dcm_locked_i};
    end
  end

  assign lk = lk_sync_q[1];
`else
  assign lk = dcm_locked_i;
`endif

  // A stopped input clock invalidates any lock indication.
  assign lk_good = lk & ~dcm_clkin_stopped_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retry_d    = retry_q;
    take_retry = 1'b0;

    case (state_q)
      StAssertRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitLock: begin
        // Lock has priority over a coincident timeout.
        if (lk_good) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LockLast) begin
          take_retry = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStable: begin
        // A dropout here only restarts qualification; the DCM is not reset.
        if (!lk_good) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: begin
        if (!lk_good) begin
          take_retry = 1'b1;
        end
      end
      StFail: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StAssertRst;
        cnt_d   = '0;
      end
    endcase

    if (take_retry) begin
      cnt_d = '0;
      if (retry_q == MaxRetry) begin
        state_d = StFail;
      end else begin
        state_d = StAssertRst;
        if (retry_q != 4'hF) begin
          retry_d = retry_q + 4'd1;
        end
      end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    dcm_rst_d = (state_d == StAssertRst) || (state_d == StFail);
    sys_rst_d = (state_d != StRun);
    lock_ok_d = (state_d == StRun);
    fail_d    = fail_q | (state_d == StFail);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StAssertRst;
      cnt_q     <= '0;
      retry_q   <= 4'd0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      lock_ok_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      dcm_rst_q <= dcm_rst_d;
      sys_rst_q <= sys_rst_d;
      lock_ok_q <= lock_ok_d;
      fail_q    <= fail_d;
    end
  end

  assign dcm_rst_o   = dcm_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign lock_ok_o   = lock_ok_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Testbench for dcm_reset_sequencer: directed bring-up scenarios followed by random
// lock/clock-stop traffic, checked cycle by cycle against a countdown-based model.
module tb_dcm_reset_sequencer;

  localparam int unsigned RstCycles    = 4;
  localparam int unsigned LockTimeout  = 20;
  localparam int unsigned StableCycles = 8;
  localparam int unsigned MaxRetries   = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       dcm_locked;
  logic       dcm_clkin_stopped;
  logic       dcm_rst;
  logic       sys_rst;
  logic       lock_ok;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  dcm_reset_sequencer #(
    .RST_CYCLES   (RstCycles),
    .LOCK_TIMEOUT (LockTimeout),
    .STABLE_CYCLES(StableCycles),
    .MAX_RETRIES  (MaxRetries),
    .CNT_W        (16)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .dcm_locked_i       (dcm_locked),
    .dcm_clkin_stopped_i(dcm_clkin_stopped),
    .dcm_rst_o          (dcm_rst),
    .sys_rst_o          (sys_rst),
    .lock_ok_o          (lock_ok),
    .fail_o             (fail),
    .retry_cnt_o        (retry_cnt),
    .state_o            (state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       dr;
    logic       sr;
    logic       lo;
    logic       fl;
    logic [3:0] rc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each phase owns a countdown of edges left before it times out.
  typedef enum int {MAssert = 0, MWait = 1, MStable = 2, MRun = 3, MFail = 4} mphase_e;

  mphase_e m_phase;
  int      m_left;
  int      m_retries;
  bit      m_fail;
  bit      lk_hist[2];

  function automatic void enter(mphase_e p);
    m_phase = p;
    case (p)
      MAssert: m_left = RstCycles;
      MWait:   m_left = LockTimeout;
      MStable: m_left = StableCycles;
      default: m_left = 0;
    endcase
  endfunction

  function automatic void model_reset();
    enter(MAssert);
    m_retries  = 0;
    m_fail     = 1'b0;
    lk_hist[0] = 1'b0;
    lk_hist[1] = 1'b0;
  endfunction

  function automatic void model_retry();
    if (m_retries == MaxRetries) begin
      m_phase = MFail;
      m_fail  = 1'b1;
    end else begin
      m_retries++;
      enter(MAssert);
    end
  endfunction

  function automatic void model_edge(bit l, bit s);
    bit lk;
`ifdef DCM_LOCK_SYNC_EN
    lk         = lk_hist[1];
    lk_hist[1] = lk_hist[0];
    lk_hist[0] = l;
`else
    lk = l;
`endif
    case (m_phase)
      MAssert: begin
        m_left--;
        if (m_left == 0) enter(MWait);
      end
      MWait: begin
        if (lk && !s) enter(MStable);
        else begin
          m_left--;
          if (m_left == 0) model_retry();
        end
      end
      MStable: begin
        if (!lk || s) enter(MWait);
        else begin
          m_left--;
          if (m_left == 0) enter(MRun);
        end
      end
      MRun: if (!lk || s) model_retry();
      default: ;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st = 3'(int'(m_phase));
    e.dr = (m_phase == MAssert) || (m_phase == MFail);
    e.sr = (m_phase != MRun);
    e.lo = (m_phase == MRun);
    e.fl = m_fail;
    e.rc = 4'(m_retries);
    return e;
  endfunction

  // Drive inputs for the coming edge, queue the model's prediction, then advance.
  task automatic cyc(bit l, bit s);
    dcm_locked        = l;
    dcm_clkin_stopped = s;
    if (reset) model_reset();
    else model_edge(l, s);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  task automatic run_until(mphase_e p, bit l, bit s, int limit);
    int n;
    n = 0;
    while (m_phase != p && n < limit) begin
      cyc(l, s);
      n++;
    end
  endtask

  task automatic check_reset_now(string name);
    logic [9:0] act;
    act = {state, dcm_rst, sys_rst, lock_ok, fail, retry_cnt};
    checks++;
    if (act !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL %s: got st=%0d dcm_rst=%b sys_rst=%b lock_ok=%b fail=%b retry=%0d, required reset values",
               name, state, dcm_rst, sys_rst, lock_ok, fail, retry_cnt);
    end
  endtask

  // Called at 2 time units past an edge; asserts reset between edges.
  task automatic async_reset_pulse(string name);
    #1;
    reset = 1'b1;
    #1;
    check_reset_now(name);
    exp_q.delete();
    model_reset();
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: one output observation per cycle, compared with the oldest prediction.
  initial begin
    forever begin : mon
      exp_t e;
      exp_t a;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {state, dcm_rst, sys_rst, lock_ok, fail, retry_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle_check t=%0t: got st=%0d dr=%b sr=%b lo=%b fl=%b rc=%0d, required st=%0d dr=%b sr=%b lo=%b fl=%b rc=%0d",
                   $time, a.st, a.dr, a.sr, a.lo, a.fl, a.rc, e.st, e.dr, e.sr, e.lo, e.fl, e.rc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    dcm_locked        = 1'b0;
    dcm_clkin_stopped = 1'b0;
    model_reset();
    cyc(0, 0);
    cyc(0, 0);
    check_reset_now("reset_state");
    reset = 1'b0;

    // Nominal bring-up: lock rises some cycles after dcm_rst falls.
    run_until(MWait, 0, 0, 50);
    repeat (5) cyc(0, 0);
    run_until(MRun, 1, 0, 100);
    repeat (5) cyc(1, 0);

    // Input clock stops for one cycle while running.
    cyc(1, 1);
    run_until(MRun, 1, 0, 100);
    repeat (3) cyc(1, 0);

    // Lock glitch at stable count 5, then full requalification.
    async_reset_pulse("reset_from_run");
    run_until(MWait, 0, 0, 50);
    repeat (3) cyc(0, 0);
    run_until(MStable, 1, 0, 10);
    repeat (5) cyc(1, 0);
    cyc(0, 0);
    run_until(MRun, 1, 0, 100);
    repeat (3) cyc(1, 0);

    // Repeated lock timeouts exhaust the retries.
    run_until(MFail, 0, 0, 400);
    repeat (10) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset out of FAIL, then reset mid-WAIT_LOCK with one retry charged.
    async_reset_pulse("reset_from_fail");
    run_until(MWait, 0, 0, 50);
    repeat (LockTimeout) cyc(0, 0);
    run_until(MWait, 0, 0, 50);
    repeat (7) cyc(0, 0);
    async_reset_pulse("reset_mid_wait");
    repeat (3) cyc(0, 0);

    // Random lock/loss traffic with occasional resets.
    repeat (80) begin : rnd
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 40);
      if (kind == 0) async_reset_pulse("reset_random");
      else if (kind < 6) repeat (len) cyc(1'b1, $urandom_range(0, 29) == 0);
      else repeat (len) cyc($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
    end

    cyc(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcm_reset_sequencer.md
Name: dcm_reset_sequencer

Overview:
- Controls the board clock DCM: drives its RST pin, waits for LOCKED, and holds the downstream system reset until the lock has been stable for a qualified interval.
- Detects lock loss or a stopped input clock, re-resets the DCM, and gives up after a bounded number of retries.
- Runs on the buffered DCM input clock, never on a DCM output.
- The system reset it produces gates the four-digit LED driver and all other logic on the divided clock.

Parameters:
- RST_CYCLES, 4: number of clk cycles dcm_rst is held high per attempt (at least 3, per the DCM minimum).
- LOCK_TIMEOUT, 50000: number of clk cycles to wait for LOCKED before the attempt counts as failed.
- STABLE_CYCLES, 1024: number of consecutive clk cycles LOCKED must stay high before sys_rst is released.
- MAX_RETRIES, 7: number of re-reset attempts allowed before FAIL; range 0..15.
- CNT_W, 16: width of the shared cycle counter; must cover max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk, input, 1: buffered DCM input clock (100 MHz).
- reset, input, 1: asynchronous, active-high reset for the whole block.
- dcm_locked, input, 1: DCM LOCKED output.
- dcm_clkin_stopped, input, 1: DCM STATUS[1], input clock stopped.
- dcm_rst, output, 1: drives the DCM RST pin; registered.
- sys_rst, output, 1: reset for the divided-clock logic; registered; active-high.
- lock_ok, output, 1: high only in RUN.
- fail, output, 1: sticky flag, set when retries are exhausted.
- retry_cnt, output, 4: number of retries performed; saturates; cleared only by reset.
- state, output, 3: current FSM state; ASSERT_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Behaviour:
- Reset asserted (asynchronous): state=ASSERT_RST, counter=0, dcm_rst=1, sys_rst=1, lock_ok=0, fail=0, retry_cnt=0.
- Internal signal lk is dcm_locked, or its synchronized version when the optional feature is compiled in. All decisions use lk.
- ASSERT_RST:
  - dcm_rst=1, sys_rst=1.
  - Counter increments every cycle.
  - When counter==RST_CYCLES-1: go to WAIT_LOCK, clear counter, drive dcm_rst=0 from the next cycle.
  - dcm_rst is therefore high for exactly RST_CYCLES edges after reset release.
- WAIT_LOCK:
  - dcm_rst=0, sys_rst=1.
  - lk=1: go to STABLE, clear counter.
  - Otherwise, when counter==LOCK_TIMEOUT-1: take the retry path.
  - Otherwise the counter increments.
- STABLE:
  - dcm_rst=0, sys_rst=1.
  - lk=0: return to WAIT_LOCK with counter cleared. No DCM reset and no retry is charged.
  - When counter==STABLE_CYCLES-1 with lk=1: go to RUN. sys_rst falls and lock_ok rises on the same edge.
- RUN:
  - dcm_rst=0, sys_rst=0, lock_ok=1.
  - lk=0 or dcm_clkin_stopped=1: take the retry path. sys_rst=1 and lock_ok=0 from the next edge.
- Retry path:
  - If retry_cnt==MAX_RETRIES: go to FAIL.
  - Else: retry_cnt+1, go to ASSERT_RST, clear counter.
- FAIL:
  - dcm_rst=1, sys_rst=1, fail=1, lock_ok=0.
  - Terminal state; only reset exits it.
- dcm_clkin_stopped in WAIT_LOCK or STABLE is treated as lk=0.
- Simultaneous lk=1 and timeout in WAIT_LOCK: lock wins, go to STABLE.
- Reset asserted mid-sequence: immediate return to the reset values; the counter does not resume.
- The counter is CNT_W bits and never wraps; every state clears it on exit.
- Unused state encodings (5..7) recover to ASSERT_RST on the next edge.

Optional Feature:
- Macro DCM_LOCK_SYNC_EN.
- Defined: dcm_locked passes through a 2-flop synchronizer (reset value 0) to form lk. All lock-driven transitions occur 2 cycles later than without it.
- Undefined: lk = dcm_locked directly, with no added latency.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, sync undefined.
- Nominal bring-up: release reset, raise dcm_locked 6 cycles after dcm_rst falls → dcm_rst high 4 cycles; state 1→2→3; sys_rst falls exactly 8 cycles after state=2; lock_ok=1; retry_cnt=0.
- Timeout: dcm_locked held 0 → dcm_rst re-asserts 20 cycles after it first falls; retry_cnt=1, then 2; on the third timeout state=4, fail=1, dcm_rst=1, sys_rst=1.
- Glitch during STABLE: drop dcm_locked for 1 cycle at stable count 5 → state returns to 1, dcm_rst stays 0, retry_cnt unchanged; on relock, a full 8 stable cycles are needed before RUN.
- Lock loss in RUN: pulse dcm_clkin_stopped for 1 cycle → next edge sys_rst=1, lock_ok=0, state=0, retry_cnt=1; normal recovery to RUN follows.
- Asynchronous reset mid-WAIT_LOCK, asserted between clock edges → outputs go to their reset values immediately (fail=0, retry_cnt=0); the sequence restarts from ASSERT_RST.
- DCM_LOCK_SYNC_EN defined, nominal bring-up → the state 1→2 transition occurs 2 cycles after dcm_locked rises; sys_rst release is likewise delayed by 2 cycles.
